// File: rtl/moa_share_arb.sv
// Round-robin scheduler sharing one pipelined multi-operand adder
// among NREQ requesters, with a latency-matched tag pipe and result FIFO.
module moa_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int NOP  = 8,
    parameter int SW   = 11,
    parameter int LAT  = 2,
    parameter int FD   = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*NOP*W-1:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NOP*W-1:0]       moa_x,
    input  logic [SW-1:0]          moa_summ,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [SW-1:0]          rsp_sum,
    output logic                   busy
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_credit;
    logic [NOP*W-1:0] r_x;
    logic [LAT-1:0]   r_tv;
    logic [IDW-1:0]   r_tid [LAT];
    logic [IDW-1:0]   r_fid [FD];
    logic [SW-1:0]    r_fsum [FD];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    logic             w_gnt_any;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_allow;
    logic             w_issue;
    logic             w_pop;
    logic             w_push;
    logic [NOP*W-1:0] w_sel;

    // Round-robin search starting at the pointer, wrapping once
    always_comb begin : p_arb
        int w_idx;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_gnt_any && req_valid[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = IDW'(w_idx);
            end
        end
    end

    assign w_allow   = !rst && (r_credit != '0);
    assign req_ready = (w_allow && w_gnt_any) ? (NREQ'(1) << w_gnt_id) : '0;
    assign w_issue   = |(req_valid & req_ready);
    assign w_sel     = req_data[int'(w_gnt_id)*NOP*W +: NOP*W];

    assign rsp_valid = !rst && (r_cnt != '0);
    assign rsp_id    = r_fid[r_rp];
    assign rsp_sum   = r_fsum[r_rp];
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_tv[LAT-1];
    assign busy      = !rst && (r_credit != CW'(FD));
    assign moa_x     = r_x;

    // Pointer advances past the granted requester on each accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;
        end
    end

    // Credits cover in-flight vectors plus buffered results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= CW'(FD);
        end else begin
            r_credit <= r_credit - CW'(w_issue) + CW'(w_pop);
        end
    end

    // Operand register feeding the shared adder
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
        end else if (w_issue) begin
            r_x <= w_sel;
        end
    end

    // Tag valid bits track the adder pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tv <= '0;
        end else begin
            r_tv[0] <= w_issue;
            for (int s = 1; s < LAT; s++) begin
                r_tv[s] <= r_tv[s-1];
            end
        end
    end

    // Tag IDs shift alongside the valid bits
    always_ff @(posedge clk) begin
        r_tid[0] <= w_gnt_id;
        for (int s = 1; s < LAT; s++) begin
            r_tid[s] <= r_tid[s-1];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == PW'(FD - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(FD - 1)) ? '0 : r_rp + 1'b1;
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage captures the tagged sum as it leaves the adder
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fid[r_wp]  <= r_tid[LAT-1];
            r_fsum[r_wp] <= moa_summ;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_cnt == CW'(FD))));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        r_credit <= CW'(FD));

endmodule
